// File: rtl/out_uart_pkg.sv
// Shared types and constants for the CPU output-port UART transmitter.
package out_uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam logic [7:0] EXIT_CODE = 8'hFF;
   localparam int         DATA_BITS = 8;

endpackage

// File: rtl/out_uart_tx_byte_fifo.sv
// Byte FIFO with an extra pointer bit for full/empty; a push and a pop in the
// same cycle while full are both accepted.
module byte_fifo #(
   parameter int  FIFO_DEPTH = 8,
   localparam int AW         = $clog2(FIFO_DEPTH)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic [7:0]  din,
   input  logic        pop,
   output logic [7:0]  dout,
   output logic        full,
   output logic        empty,
   output logic [AW:0] level
);

   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level   = wr_ptr - rd_ptr;
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/out_uart_tx.sv
// Captures CPU OUT bytes into a FIFO and sends them as 8N1 UART on tx.
// Optional: OUT_UART_HALT_ON_FF_EN turns byte 0xFF into a sticky exit request.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); pops the next byte on its last cycle for gapless frames
module out_uart_tx
   import out_uart_pkg::*;
#(
   parameter int  CLKS_PER_BIT = 16,
   parameter int  FIFO_DEPTH   = 8,
   localparam int LW           = $clog2(FIFO_DEPTH) + 1,
   localparam int BW           = $clog2(CLKS_PER_BIT)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [7:0]    out,
   input  logic          outOn,
   output logic          tx,
   output logic          busy,
   output logic [LW-1:0] level,
   output logic          overflow,
   output logic          exit_req
);

   tx_state_t      state_q;
   logic [BW-1:0]  baud_q;
   logic [2:0]     bit_q;
   logic [7:0]     shift_q;
   logic           outon_q;
   logic           strobe;
   logic           fifo_push;
   logic           fifo_pop;
   logic           fifo_full;
   logic           fifo_empty;
   logic [7:0]     fifo_dout;
   logic           baud_last;

   // outon_q resets high so a strobe held across reset release is not captured
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) outon_q <= 1'b1;
      else        outon_q <= outOn;
   end

   assign strobe = outOn & ~outon_q;

`ifdef OUT_UART_HALT_ON_FF_EN
   logic exit_pending_q;
   logic exit_hold_q;
   logic accept;

   assign accept    = strobe & ~exit_pending_q;
   assign fifo_push = accept & (out != EXIT_CODE);
   assign exit_req  = exit_hold_q | (exit_pending_q & (level == '0) & (state_q == IDLE));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         exit_pending_q <= 1'b0;
         exit_hold_q    <= 1'b0;
      end else begin
         if (accept && (out == EXIT_CODE)) exit_pending_q <= 1'b1;
         if (exit_req) exit_hold_q <= 1'b1;
      end
   end
`else
   assign fifo_push = strobe;
   assign exit_req  = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                 overflow <= 1'b0;
      else if (fifo_push & fifo_full & ~fifo_pop) overflow <= 1'b1;
   end

   byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .din   (out),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));
   assign fifo_pop  = ~fifo_empty & ((state_q == IDLE) | ((state_q == STOP) & baud_last));
   assign busy      = (state_q != IDLE) | (level != '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx      <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  shift_q <= fifo_dout;
                  state_q <= START;
                  baud_q  <= '0;
                  tx      <= 1'b0;
               end
            end
            START: begin
               if (baud_last) begin
                  tx      <= shift_q[0];
                  shift_q <= shift_q >> 1;
                  bit_q   <= '0;
                  baud_q  <= '0;
                  state_q <= DATA;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            DATA: begin
               if (baud_last) begin
                  baud_q <= '0;
                  if (bit_q == 3'(DATA_BITS - 1)) begin
                     tx      <= 1'b1;
                     state_q <= STOP;
                  end else begin
                     tx      <= shift_q[0];
                     shift_q <= shift_q >> 1;
                     bit_q   <= bit_q + 1'b1;
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            STOP: begin
               if (baud_last) begin
                  baud_q <= '0;
                  if (!fifo_empty) begin
                     shift_q <= fifo_dout;
                     tx      <= 1'b0;
                     state_q <= START;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/out_uart_tx.md
Name: out_uart_tx

Overview:
- Downstream consumer of the CPU top's output port (`out[7:0]` and the `outOn` strobe).
- Captures every byte the CPU emits with `OUT` into a small FIFO, then serialises it as 8N1 UART on `tx`.
- Lets bench and board observe CPU output without stalling the CPU; the CPU has no backpressure input.
- Optionally intercepts the exit code 0xFF.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit (>=2).
- FIFO_DEPTH, 8, byte FIFO entries (power of 2, >=2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- out  input  8  byte from the CPU output port.
- outOn  input  1  CPU output strobe; may stay high for more than one cycle.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high while the FIFO is non-empty or a frame is in flight.
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky; a byte was dropped because the FIFO was full.
- exit_req  output  1  exit request; see Optional Feature.

Behaviour:
- Clock and reset: single clock domain; reset is asynchronous, active-low.
- Reset values: tx=1, busy=0, level=0, overflow=0, exit_req=0, FSM in IDLE, bit and baud counters 0, FIFO pointers 0, outOn_q=1.
- outOn_q resets to 1, so a strobe still held high across reset release is not captured.
- Reset mid-frame aborts the frame immediately: tx returns high and queued bytes are lost.
- Capture: push = outOn & ~outOn_q (rising-edge detect, registered). `out` is sampled on the same edge. One byte per strobe, regardless of how long outOn stays high.
- Full FIFO:
  - A push while full and with no pop that cycle drops the byte and sets overflow.
  - overflow stays set until reset.
  - A push and pop in the same cycle while full are both accepted; level is unchanged.
- Empty FIFO: no pop occurs; tx stays high.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop into shift register, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; bit counter 0..7; then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the last STOP cycle, if the FIFO is non-empty, pop and go directly to START (zero-gap frames); otherwise go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps.
  - Reset to 0 on every state entry.
  - Width $clog2(CLKS_PER_BIT).
- tx is registered.
- Latency: with the FIFO empty and the FSM in IDLE, if the edge-detected push occurs at edge k, then tx falls after edge k+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- busy = (state!=IDLE) | (level!=0).

Optional Feature:
- Macro: OUT_UART_HALT_ON_FF_EN.
- Defined:
  - A captured byte equal to 0xFF is not pushed; instead it sets exit_pending.
  - All later strobes are ignored; overflow is not affected by them.
  - exit_req goes high on the first cycle where exit_pending=1, level=0 and state=IDLE, i.e. after every earlier byte has fully transmitted.
  - exit_req is sticky until reset.
- Undefined: 0xFF is transmitted like any other byte; exit_req is tied 0.

Decomposition:
- Package out_uart_pkg:
  - tx_state_t enum {IDLE, START, DATA, STOP}
  - localparam EXIT_CODE = 8'hFF
  - localparam DATA_BITS = 8
- Sub-module byte_fifo:
  - Parameterised synchronous FIFO with a FIFO_DEPTH-entry memory and an extra pointer bit for the full/empty distinction.
  - Ports: clk, reset, push, din, pop, dout, full, empty, level.
  - Simultaneous push and pop while full are both accepted.
- out_uart_tx holds the edge detect, the FSM, the counters and the exit logic.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Single byte: one 1-cycle strobe with out=8'h41. Required: tx low 4 cycles, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then high 4 cycles. tx falls one cycle after capture; busy drops after 40 cycles.
- Long strobe: outOn held high 10 cycles with out=8'h55. Required: exactly one frame; level peaks at 1.
- Burst and overflow: 6 strobes 2 cycles apart (0x01..0x06), first pushed while idle. Required:
  - 0x01 is popped one cycle after push; 0x02..0x05 fill the FIFO (level=4); 0x06 is dropped and overflow=1.
  - Frames 0x01..0x05 are sent back-to-back with no idle gap; overflow remains 1.
- Reset mid-frame: assert reset during DATA of 0x3C. Required: tx=1, level=0 and busy=0 immediately. Next strobe after release transmits normally.
- Strobe held through reset: outOn=1 while reset releases. Required: no push until outOn falls and rises again.
- Exit code (OUT_UART_HALT_ON_FF_EN defined): strobes 0x48 then 0xFF then 0x49. Required: only 0x48 transmitted; exit_req rises on the first cycle after its stop bit completes; 0x49 ignored. Without the macro: 0x48, 0xFF and 0x49 are all sent and exit_req stays 0.
